dec_scan_ctrl: RTL

Sequential scan controller that drives the select code and enable of the team's 3-to-8 decoders (shift and case variants). It sweeps the 3-bit select through the eight decoder lines under a per-line dwell count, with a blanking gap between lines and a line mask for skipping lines. It runs as a one-shot sweep or continuously. The `sel`/`en` outputs connect directly to the decoder `in`/`en` ports.

---
 rtl/dec_scan_if.sv | 27 ++
 rtl/dec_scan_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dec_scan_if.sv
// Control/status bundle between a scan requester and dec_scan_ctrl.
// sel/en are meant to be wired straight to a 3-to-8 decoder's in/en.
interface dec_scan_if #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned BLANK_W = 4
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, mask, dwell, blank,
        input  sel, en, busy, done
    );

    modport slave (
        input  start, stop, mode, mask, dwell, blank,
        output sel, en, busy, done
    );
endinterface

// File: rtl/dec_scan_ctrl.sv
// Sweeps a 3-to-8 decoder select through the masked lines with a per-line
// dwell and an optional blanking gap; one-shot or continuous.
module dec_scan_ctrl #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned BLANK_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dec_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [BLANK_W-1:0] blank_q;
    logic               mode_q;
    logic [DWELL_W-1:0] dcnt;
    logic [BLANK_W-1:0] bcnt;
    logic [2:0]         sel_q;
    logic               en_q;
    logic               busy_q;
    logic               done_q;

    // Returns {found, line}: lowest set bit of m, optionally strictly above cur.
    function automatic logic [3:0] pick(input logic [7:0] m, input logic [2:0] cur,
                                        input logic above);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (!above || i > int'(cur))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] first_c;
    logic [3:0] next_c;
    logic [3:0] wrap_c;

    always_comb begin
        first_c = pick(bus.mask, 3'd0, 1'b0);
        next_c  = pick(mask_q, sel_q, 1'b1);
        wrap_c  = pick(mask_q, 3'd0, 1'b0);
    end

    // Dwell of 0 behaves as 1, so the last-cycle count is max(dwell,1)-1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == DWELL_W'(0)) ? DWELL_W'(0) : DWELL_W'(d - DWELL_W'(1));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask_q  <= 8'd0;
            dwell_q <= DWELL_W'(0);
            blank_q <= BLANK_W'(0);
            mode_q  <= 1'b0;
            dcnt    <= DWELL_W'(0);
            bcnt    <= BLANK_W'(0);
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && (bus.mask != 8'd0)) begin
                        mask_q  <= bus.mask;
                        dwell_q <= bus.dwell;
                        blank_q <= bus.blank;
                        mode_q  <= bus.mode;
                        sel_q   <= first_c[2:0];
                        busy_q  <= 1'b1;
                        if (bus.blank != BLANK_W'(0)) begin
                            state <= BLANK;
                            bcnt  <= BLANK_W'(bus.blank - BLANK_W'(1));
                            en_q  <= 1'b0;
                        end else begin
                            state <= DRIVE;
                            dcnt  <= dwell_load(bus.dwell);
                            en_q  <= 1'b1;
                        end
                    end
                end
                BLANK, DRIVE: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        sel_q  <= 3'd0;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (state == BLANK) begin
                        if (bcnt == BLANK_W'(0)) begin
                            state <= DRIVE;
                            dcnt  <= dwell_load(dwell_q);
                            en_q  <= 1'b1;
                        end else begin
                            bcnt <= BLANK_W'(bcnt - BLANK_W'(1));
                        end
                    end else if (dcnt != DWELL_W'(0)) begin
                        dcnt <= DWELL_W'(dcnt - DWELL_W'(1));
                    end else if (next_c[3] || mode_q) begin
                        // Advance to the next enabled line, wrapping in continuous mode.
                        sel_q <= next_c[3] ? next_c[2:0] : wrap_c[2:0];
                        if (blank_q != BLANK_W'(0)) begin
                            state <= BLANK;
                            bcnt  <= BLANK_W'(blank_q - BLANK_W'(1));
                            en_q  <= 1'b0;
                        end else begin
                            state <= DRIVE;
                            dcnt  <= dwell_load(dwell_q);
                            en_q  <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        sel_q  <= 3'd0;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel_q  <= 3'd0;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
